// File: rtl/idx_sequencer_if.sv
// Handshake bundle between an index sequencer and whatever programs it.
// With SEQ_ONESHOT_EN defined the bundle also carries oneshot and done.
interface idx_sequencer_if #(
   parameter int unsigned DIV_WIDTH = 16
) ();
   logic                 en;
   logic [1:0]           mode;
   logic [DIV_WIDTH-1:0] div_val;
   logic                 load;
   logic [2:0]           load_idx;
   logic [2:0]           idx;
   logic                 dir;
   logic                 step;
   logic                 wrap;
`ifdef SEQ_ONESHOT_EN
   logic                 oneshot;
   logic                 done;

   modport master (
      output en, mode, div_val, load, load_idx, oneshot,
      input  idx, dir, step, wrap, done
   );
   modport slave (
      input  en, mode, div_val, load, load_idx, oneshot,
      output idx, dir, step, wrap, done
   );
`else
   modport master (
      output en, mode, div_val, load, load_idx,
      input  idx, dir, step, wrap
   );
   modport slave (
      input  en, mode, div_val, load, load_idx,
      output idx, dir, step, wrap
   );
`endif
endinterface

// File: rtl/idx_sequencer.sv
// Timed 3-bit index generator (up/down/ping-pong/hold) feeding a 3-to-8 decoder.
// Optional one-shot stop behaviour is enabled by defining SEQ_ONESHOT_EN.
module idx_sequencer #(
   parameter int unsigned DIV_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   idx_sequencer_if.slave bus
);
   localparam int unsigned IDX_W = 3;

   logic [DIV_WIDTH-1:0] presc_q, presc_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 dir_q, dir_d;
   logic                 step_q, step_d;
   logic                 wrap_q, wrap_d;
   logic                 done_q, done_d;
   logic                 oneshot_c;
   logic                 tick_c;

`ifdef SEQ_ONESHOT_EN
   assign oneshot_c = bus.oneshot;
`else
   assign oneshot_c = 1'b0;
`endif

   assign tick_c = bus.en && (presc_q >= bus.div_val);

   // Next-state: load beats enable; a tick while done is latched moves nothing.
   always_comb begin
      presc_d = presc_q;
      idx_d   = idx_q;
      dir_d   = dir_q;
      step_d  = 1'b0;
      wrap_d  = 1'b0;
      done_d  = done_q;
      if (bus.load) begin
         idx_d   = bus.load_idx;
         presc_d = '0;
         dir_d   = (bus.mode == 2'b01);
         done_d  = 1'b0;
      end else if (bus.en) begin
         presc_d = tick_c ? '0 : presc_q + DIV_WIDTH'(1);
         if (tick_c && !done_q) begin
            unique case (bus.mode)
               2'b00: begin
                  dir_d = 1'b0;
                  if (oneshot_c && idx_q == 3'd7) begin
                     done_d = 1'b1;
                     wrap_d = 1'b1;
                  end else begin
                     idx_d  = idx_q + 3'd1;
                     step_d = 1'b1;
                     wrap_d = (idx_q == 3'd7);
                  end
               end
               2'b01: begin
                  dir_d = 1'b1;
                  if (oneshot_c && idx_q == 3'd0) begin
                     done_d = 1'b1;
                     wrap_d = 1'b1;
                  end else begin
                     idx_d  = idx_q - 3'd1;
                     step_d = 1'b1;
                     wrap_d = (idx_q == 3'd0);
                  end
               end
               2'b10: begin
                  step_d = 1'b1;
                  // An endpoint reached with the wrong direction turns silently.
                  if (!dir_q) begin
                     if (idx_q == 3'd7) begin
                        dir_d = 1'b1;
                        idx_d = 3'd6;
                     end else begin
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd6) begin
                           dir_d  = 1'b1;
                           wrap_d = 1'b1;
                        end
                     end
                  end else begin
                     if (idx_q == 3'd0) begin
                        dir_d = 1'b0;
                        idx_d = 3'd1;
                     end else begin
                        idx_d = idx_q - 3'd1;
                        if (idx_q == 3'd1) begin
                           dir_d  = 1'b0;
                           wrap_d = 1'b1;
                           done_d = oneshot_c;
                        end
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
         idx_q   <= '0;
         dir_q   <= 1'b0;
         step_q  <= 1'b0;
         wrap_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         dir_q   <= dir_d;
         step_q  <= step_d;
         wrap_q  <= wrap_d;
         done_q  <= done_d;
      end
   end

   assign bus.idx  = idx_q;
   assign bus.dir  = dir_q;
   assign bus.step = step_q;
   assign bus.wrap = wrap_q;
`ifdef SEQ_ONESHOT_EN
   assign bus.done = done_q;
`endif

endmodule

// File: tb/tb_idx_sequencer.sv
// Directed and randomized bench for idx_sequencer with a phase-based reference model.
// Exercises the one-shot behaviour too when SEQ_ONESHOT_EN is defined.
module tb_idx_sequencer;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   // reference model state
   int m_idx, m_dir, m_presc, m_step, m_wrap, m_done;

   idx_sequencer_if #(.DIV_WIDTH(16)) bus ();
   idx_sequencer #(.DIV_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int os_in();
`ifdef SEQ_ONESHOT_EN
      return int'(bus.oneshot);
`else
      return 0;
`endif
   endfunction

   // Ping-pong is a walk around a 14-position ring: idx = p for p<=7, else 14-p.
   task automatic model_step();
      int  p;
      bit  tick;
      m_step = 0;
      m_wrap = 0;
      if (!rst_n) begin
         m_idx = 0; m_dir = 0; m_presc = 0; m_done = 0;
      end else if (bus.load) begin
         m_idx = int'(bus.load_idx); m_presc = 0; m_done = 0;
         m_dir = (bus.mode == 2'b01) ? 1 : 0;
      end else if (bus.en) begin
         tick    = (m_presc >= int'(bus.div_val));
         m_presc = tick ? 0 : m_presc + 1;
         if (tick && m_done == 0) begin
            case (int'(bus.mode))
               0: begin
                  m_dir = 0;
                  if (os_in() != 0 && m_idx == 7) begin m_done = 1; m_wrap = 1; end
                  else begin m_wrap = (m_idx == 7); m_idx = (m_idx + 1) % 8; m_step = 1; end
               end
               1: begin
                  m_dir = 1;
                  if (os_in() != 0 && m_idx == 0) begin m_done = 1; m_wrap = 1; end
                  else begin m_wrap = (m_idx == 0); m_idx = (m_idx + 7) % 8; m_step = 1; end
               end
               2: begin
                  if ((m_dir == 0 && m_idx == 7) || (m_dir == 1 && m_idx == 0)) m_dir = 1 - m_dir;
                  p      = (m_dir != 0) ? (14 - m_idx) % 14 : m_idx;
                  p      = (p + 1) % 14;
                  m_idx  = (p <= 7) ? p : 14 - p;
                  m_dir  = (p >= 7) ? 1 : 0;
                  m_wrap = (p == 7 || p == 0) ? 1 : 0;
                  m_step = 1;
                  if (os_in() != 0 && p == 0) m_done = 1;
               end
               default: ;
            endcase
         end
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check("model_idx",  32'(bus.idx),  32'(m_idx));
      check("model_dir",  32'(bus.dir),  32'(m_dir));
      check("model_step", 32'(bus.step), 32'(m_step));
      check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
`ifdef SEQ_ONESHOT_EN
      check("model_done", 32'(bus.done), 32'(m_done));
`endif
   endtask

   initial begin : stim
      int n;
      int cnt;
      bit got;
      int down_seq[4];
      int down_wrp[4];
      int pp_seq[10];
      int pp_wrp[10];
      int pp_dir[10];
      down_seq = '{1, 0, 7, 6};
      down_wrp = '{0, 0, 1, 0};
      pp_seq   = '{6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
      pp_wrp   = '{0, 1, 0, 0, 0, 0, 0, 0, 1, 0};
      pp_dir   = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 0};

      bus.en = 1'b0; bus.mode = 2'b00; bus.div_val = 16'd3;
      bus.load = 1'b0; bus.load_idx = 3'd0;
`ifdef SEQ_ONESHOT_EN
      bus.oneshot = 1'b0;
`endif
      // 1: reset then up count, period 4
      rst_n = 1'b0;
      cycle(); cycle();
      check("rst_idx", 32'(bus.idx), 0);
      check("rst_step", 32'(bus.step), 0);
      check("rst_wrap", 32'(bus.wrap), 0);
      rst_n = 1'b1; bus.en = 1'b1;
      for (int k = 1; k <= 32; k++) begin
         cycle();
         check("up_step", 32'(bus.step), (k % 4 == 0) ? 1 : 0);
         check("up_idx",  32'(bus.idx),  (k / 4) % 8);
         check("up_wrap", 32'(bus.wrap), (k == 32) ? 1 : 0);
      end

      // 2: down, div_val 0, load 2
      bus.mode = 2'b01; bus.div_val = 16'd0; bus.load = 1'b1; bus.load_idx = 3'd2;
      cycle();
      bus.load = 1'b0;
      check("down_load_idx", 32'(bus.idx), 2);
      check("down_load_dir", 32'(bus.dir), 1);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("down_idx",  32'(bus.idx),  32'(down_seq[k]));
         check("down_wrap", 32'(bus.wrap), 32'(down_wrp[k]));
      end

      // 3: ping-pong from 5
      bus.mode = 2'b10; bus.load = 1'b1; bus.load_idx = 3'd5;
      cycle();
      bus.load = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         check("pp_idx",  32'(bus.idx),  32'(pp_seq[k]));
         check("pp_wrap", 32'(bus.wrap), 32'(pp_wrp[k]));
         check("pp_dir",  32'(bus.dir),  32'(pp_dir[k]));
      end

      // 4a: freeze prescaler at 5, re-enable, tick on 5th enabled edge
      bus.mode = 2'b00; bus.div_val = 16'd9; bus.load = 1'b1; bus.load_idx = 3'd0;
      cycle();
      bus.load = 1'b0;
      repeat (5) cycle();
      bus.en = 1'b0;
      cnt = 0;
      repeat (10) begin cycle(); cnt += int'(bus.step); end
      check("frozen_steps", 32'(cnt), 0);
      bus.en = 1'b1;
      n = 0; got = 1'b0;
      for (int i = 1; i <= 20 && !got; i++) begin
         cycle();
         if (bus.step) begin n = i; got = 1'b1; end
      end
      check("reenable_latency", 32'(n), 5);
      check("reenable_idx", 32'(bus.idx), 1);

      // 4b: hold mode gives no steps
      bus.mode = 2'b11; bus.div_val = 16'd0;
      cnt = 0;
      repeat (12) begin cycle(); cnt += int'(bus.step); end
      check("hold_steps", 32'(cnt), 0);
      check("hold_idx", 32'(bus.idx), 1);

      // 4c: load wins over en=0
      bus.en = 1'b0; bus.mode = 2'b00; bus.load = 1'b1; bus.load_idx = 3'd6;
      cycle();
      bus.load = 1'b0; bus.en = 1'b1;
      check("load_en0_idx", 32'(bus.idx), 6);
      check("load_en0_step", 32'(bus.step), 0);

      // 5: div_val shrink below running prescaler
      bus.div_val = 16'd100; bus.load = 1'b1; bus.load_idx = 3'd0;
      cycle();
      bus.load = 1'b0;
      repeat (50) cycle();
      bus.div_val = 16'd10;
      cycle();
      check("shrink_tick", 32'(bus.step), 1);
      for (int k = 1; k <= 11; k++) begin
         cycle();
         check("shrink_period", 32'(bus.step), (k == 11) ? 1 : 0);
      end

`ifdef SEQ_ONESHOT_EN
      // 6: one-shot up stops at 7
      bus.oneshot = 1'b1; bus.div_val = 16'd0; bus.load = 1'b1; bus.load_idx = 3'd6;
      cycle();
      bus.load = 1'b0;
      cycle();
      check("os_idx7", 32'(bus.idx), 7);
      cycle();
      check("os_done", 32'(bus.done), 1);
      check("os_wrap", 32'(bus.wrap), 1);
      check("os_nostep", 32'(bus.step), 0);
      cnt = 0;
      repeat (20) begin cycle(); cnt += int'(bus.wrap) + int'(bus.step); end
      check("os_quiet", 32'(cnt), 0);
      check("os_hold_idx", 32'(bus.idx), 7);
      bus.load = 1'b1; bus.load_idx = 3'd3;
      cycle();
      bus.load = 1'b0;
      check("os_load_clear", 32'(bus.done), 0);
`endif

      // randomized stretch against the model
      for (int k = 0; k < 600; k++) begin
         rst_n        = ($urandom_range(0, 63) != 0);
         bus.en       = ($urandom_range(0, 7) != 0);
         bus.mode     = 2'($urandom_range(0, 3));
         bus.div_val  = 16'($urandom_range(0, 3));
         bus.load     = ($urandom_range(0, 15) == 0);
         bus.load_idx = 3'($urandom_range(0, 7));
`ifdef SEQ_ONESHOT_EN
         bus.oneshot  = ($urandom_range(0, 3) == 0);
`endif
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
